// File: rtl/indexed_partsel_pipe.sv
// indexed_partsel_pipe: two-stage pipelined indexed part-select (+: / -:)
// over a source vector whose declared bounds may be ascending or descending.
// Out-of-range slice bits are replaced by FILL and flagged in a per-bit mask.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The producer holds valid and its payload until that edge. A result
// is never dropped, duplicated or reordered, and the payload stays stable
// while valid is high and ready is low.
module indexed_partsel_pipe #(
  parameter int   MSB  = 4,
  parameter int   LSB  = -2,
  parameter int   W    = 3,
  parameter int   SELW = 5,
  parameter logic FILL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSB:LSB]         in_data,
  input  logic signed [SELW-1:0] in_sel,
  input  logic                   in_down,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [W-1:0]           out_inrange,
  output logic                   out_oob,
  output logic [15:0]            oob_cnt
);

  localparam bit BIG  = (MSB < LSB);
  localparam int N    = BIG ? (LSB - MSB + 1) : (MSB - LSB + 1);
  localparam int IMIN = BIG ? MSB : LSB;
  localparam int IMAX = BIG ? LSB : MSB;
  // Wide enough that in_sel - (W-1) and lo + (W-1) never wrap.
  localparam int IW   = SELW + $clog2(W) + 2;

  localparam logic signed [IW-1:0] IMIN_S = IW'(IMIN);
  localparam logic signed [IW-1:0] IMAX_S = IW'(IMAX);
  localparam logic signed [IW-1:0] WM1_S  = IW'(W - 1);

  logic [N-1:0]          flat;
  logic [N-1:0]          norm;     // norm[j] = source bit at index IMIN+j
  logic signed [IW-1:0]  sel_ext;
  logic signed [IW-1:0]  in_lo;

  logic                  s1_valid;
  logic [N-1:0]          s1_norm;
  logic signed [IW-1:0]  s1_lo;
  logic                  s1_down;

  logic                  s2_load;
  logic                  accept;
  logic                  consume;

  logic signed [IW-1:0]  idx   [W];
  logic [IW-1:0]         off   [W];
  logic [N-1:0]          shf   [W];
  logic                  legal [W];
  logic [W-1:0]          nxt_data;
  logic [W-1:0]          nxt_mask;

  assign flat    = in_data;
  assign sel_ext = IW'(in_sel);
  assign in_lo   = in_down ? (sel_ext - WM1_S) : sel_ext;

  // Reorder the source so bit j always holds index IMIN+j, whatever the endianness.
  always_comb begin
    norm = '0;
    for (int j = 0; j < N; j++) begin
      if (BIG) norm[j] = flat[N-1-j];
      else     norm[j] = flat[j];
    end
  end

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = rst_n && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Stage 1: capture normalised data, low index and direction on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_norm  <= '0;
      s1_lo    <= '0;
      s1_down  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_norm <= norm;
        s1_lo   <= in_lo;
        s1_down <= in_down;
      end
    end
  end

  // Per-bit extraction: legal indices pull from the source, others take FILL.
  always_comb begin
    nxt_data = '0;
    nxt_mask = '0;
    for (int k = 0; k < W; k++) begin
      idx[k]   = s1_lo + IW'(k);
      legal[k] = (idx[k] >= IMIN_S) && (idx[k] <= IMAX_S);
      off[k]   = idx[k] - IMIN_S;
      shf[k]   = s1_norm >> off[k];
      if (BIG) begin
        nxt_data[W-1-k] = legal[k] ? shf[k][0] : FILL;
        nxt_mask[W-1-k] = legal[k];
      end else begin
        nxt_data[k] = legal[k] ? shf[k][0] : FILL;
        nxt_mask[k] = legal[k];
      end
    end
  end

  // Stage 2: load the result when empty or being consumed; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inrange <= '0;
      out_oob     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= nxt_data;
        out_inrange <= nxt_mask;
        out_oob     <= (nxt_mask == '0);
      end
    end
  end

  // Count delivered results with at least one out-of-range bit, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_cnt <= '0;
    end else if (consume && !(&out_inrange) && (oob_cnt != 16'hFFFF)) begin
      oob_cnt <= oob_cnt + 16'd1;
    end
  end

  // s1_down is kept with the request for observability of the direction used.
  logic unused_down;
  assign unused_down = s1_down;

endmodule
